// File: rtl/tic_tac_toe_pkg.sv
// Shared constants and FSM encoding for the board-cell selection path.
// BLINK_HALF_DEFAULT is only consumed when CELL_BLINK_EN is defined.
package tic_tac_toe_pkg;

  localparam int unsigned N_CELLS            = 16;
  localparam int unsigned IDX_W              = 4;
  localparam int unsigned BLINK_HALF_DEFAULT = 12_500_000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECTED = 2'd1,
    COMMIT   = 2'd2
  } state_e;

endpackage : tic_tac_toe_pkg

// File: rtl/decoder_4_16.sv
// Combinational index-to-one-hot decoder: index k drives bit k.
module decoder_4_16
  import tic_tac_toe_pkg::*;
(
  input  logic [IDX_W-1:0]   i_idx,
  output logic [N_CELLS-1:0] o_onehot
);

  assign o_onehot = N_CELLS'(1) << i_idx;

endmodule : decoder_4_16

// File: rtl/cell_select_decoder.sv
// Holds the selected board cell as a registered one-hot, rejects occupied cells and
// emits a one-cycle commit pulse. Optional blinking of the selection under CELL_BLINK_EN.
module cell_select_decoder
  import tic_tac_toe_pkg::*;
#(
  parameter int unsigned BLINK_HALF = BLINK_HALF_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               idx_valid_i,
  output logic               idx_ready_o,
  input  logic [N_CELLS-1:0] occupied_i,
  input  logic               commit_i,
  input  logic               clear_i,
  output logic [N_CELLS-1:0] sel_onehot_o,
  output logic               sel_valid_o,
  output logic [N_CELLS-1:0] commit_onehot_o,
  output logic               commit_valid_o,
  output logic               reject_o
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [N_CELLS-1:0] w_idx_onehot;
  logic [N_CELLS-1:0] r_sel;
  logic [N_CELLS-1:0] w_sel_nxt;
  logic [N_CELLS-1:0] r_commit_onehot;
  logic [N_CELLS-1:0] w_commit_onehot_nxt;
  logic               r_commit_valid;
  logic               w_commit_valid_nxt;
  logic               r_reject;
  logic               w_reject_nxt;
  logic               w_idx_ready;
  logic               w_accept;
  logic               w_idx_occ;
  logic               w_sel_occ;

  decoder_4_16 u_decoder (
    .i_idx    (idx_i),
    .o_onehot (w_idx_onehot)
  );

  assign w_idx_occ = |(occupied_i & w_idx_onehot);
  assign w_sel_occ = |(occupied_i & r_sel);

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state always uses <= so every flop samples pre-edge values.
      r_state <= w_state_nxt;
    end
  end

  // Ready drops in the same cycle a clear or commit wins, so a competing index is never taken.
  always_comb begin
    w_idx_ready = 1'b0;
    case (r_state)
      IDLE:     w_idx_ready = 1'b1;
      SELECTED: w_idx_ready = !clear_i && !commit_i;
      default:  w_idx_ready = 1'b0;
    endcase
  end

  assign w_accept = idx_valid_i && w_idx_ready;

  always_comb begin
    // NOTE: assigning a default first keeps every path covered and prevents latch inference.
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_idx_occ) w_state_nxt = SELECTED;
      end
      SELECTED: begin
        if (clear_i)                     w_state_nxt = IDLE;
        else if (commit_i && w_sel_occ)  w_state_nxt = IDLE;
        else if (commit_i)               w_state_nxt = COMMIT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sel_nxt           = r_sel;
    w_commit_onehot_nxt = '0;
    w_commit_valid_nxt  = 1'b0;
    w_reject_nxt        = w_accept && w_idx_occ;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_idx_occ) w_sel_nxt = w_idx_onehot;
      end
      SELECTED: begin
        if (clear_i) begin
          w_sel_nxt = '0;
        end else if (commit_i) begin
          w_sel_nxt = '0;
          if (w_sel_occ) begin
            w_reject_nxt = 1'b1;
          end else begin
            w_commit_onehot_nxt = r_sel;
            w_commit_valid_nxt  = 1'b1;
          end
        end else if (w_accept && !w_idx_occ) begin
          w_sel_nxt = w_idx_onehot;
        end
      end
      default: w_sel_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel           <= '0;
      r_commit_onehot <= '0;
      r_commit_valid  <= 1'b0;
      r_reject        <= 1'b0;
    end else begin
      r_sel           <= w_sel_nxt;
      r_commit_onehot <= w_commit_onehot_nxt;
      r_commit_valid  <= w_commit_valid_nxt;
      r_reject        <= w_reject_nxt;
    end
  end

  assign idx_ready_o     = w_idx_ready;
  assign sel_valid_o     = (r_state == SELECTED);
  assign commit_onehot_o = r_commit_onehot;
  assign commit_valid_o  = r_commit_valid;
  assign reject_o        = r_reject;

`ifdef CELL_BLINK_EN
  localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink_on;

  // Each accepted index restarts the blink in its visible phase.
  always_ff @(posedge clk) begin
    if (!rst_n || w_accept || r_state != SELECTED) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == CNT_W'(BLINK_HALF - 1)) begin
      r_blink_cnt <= '0;
      r_blink_on  <= !r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign sel_onehot_o = r_sel & {N_CELLS{r_blink_on}};
`else
  logic w_unused_blink;
  assign w_unused_blink = (BLINK_HALF == 0);
  assign sel_onehot_o   = r_sel;
`endif

endmodule : cell_select_decoder
